// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting sequencer for the digital clock.
// Walks RUN -> SET_HR -> SET_MIN -> RUN on mode presses, issues one-cycle
// hour/minute increment strobes, drives run enable and a field blink phase,
// and drops back to RUN after an idle timeout in a set state.
// Build option: define CLOCK_SET_AUTOREPEAT_EN to add hold-to-repeat strobes.
module clock_set_ctrl #(
    parameter int unsigned LONG_CYCLES    = 50000000,
    parameter int unsigned REPEAT_CYCLES  = 12500000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned BLINK_CYCLES   = 25000000,
    parameter int unsigned CW             = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prev_mode;
    logic            r_prev_inc;
    logic            w_rise_mode;
    logic            w_rise_inc;
    logic            w_set;
    logic            w_rep;
    logic            w_strobe;
    logic            w_timeout;
    logic [CW-1:0]   r_to_cnt;
    logic [CW-1:0]   r_blink_cnt;
    logic [CW-1:0]   w_to_nxt;
    logic [CW-1:0]   w_blink_cnt_nxt;
    logic            w_blink_nxt;
    logic            w_inc_hr_nxt;
    logic            w_inc_min_nxt;
    logic            r_inc_hr;
    logic            r_inc_min;
    logic            r_blink;
    logic            r_run_en;

    // Every cycle count must be representable in the CW-bit counters.
    if ($clog2(LONG_CYCLES + 1) > CW || $clog2(REPEAT_CYCLES + 1) > CW ||
        $clog2(TIMEOUT_CYCLES + 1) > CW || $clog2(BLINK_CYCLES + 1) > CW) begin : g_cw_check
        $error("clock_set_ctrl: CW too narrow for cycle parameters");
    end

    assign w_rise_mode = btn_mode & ~r_prev_mode;
    assign w_rise_inc  = btn_inc & ~r_prev_inc;
    assign w_set       = (r_state != ST_RUN);

`ifdef CLOCK_SET_AUTOREPEAT_EN
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_inc;
    logic          r_hold_rep;

    assign w_hold_inc = r_hold_cnt + CW'(1);
    // r_hold_rep selects the repeat interval once the first long-hold strobe has fired
    assign w_rep = w_set & ~w_rise_mode & btn_inc & r_prev_inc &
                   (w_hold_inc == (r_hold_rep ? CW'(REPEAT_CYCLES) : CW'(LONG_CYCLES)));

    // Hold counter: counts held cycles in set states, reloads after each repeat strobe
    always_ff @(posedge clk) begin
        if (rst || !w_set || w_rise_mode || w_timeout || !btn_inc || w_rise_inc) begin
            r_hold_cnt <= '0;
            r_hold_rep <= 1'b0;
        end else if (w_rep) begin
            r_hold_cnt <= '0;
            r_hold_rep <= 1'b1;
        end else begin
            r_hold_cnt <= w_hold_inc;
        end
    end
`else
    assign w_rep = 1'b0;
`endif

    assign w_strobe  = w_set & ~w_rise_mode & (w_rise_inc | w_rep);
    assign w_timeout = w_set & ~w_rise_mode & ~w_strobe &
                       (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

    // State register plus button history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_prev_mode <= 1'b0;
            r_prev_inc  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev_mode <= btn_mode;
            r_prev_inc  <= btn_inc;
        end
    end

    // Next state: mode press advances, idle timeout returns to RUN
    always_comb begin
        w_state_nxt = r_state;
        if (w_rise_mode) begin
            case (r_state)
                ST_RUN:    w_state_nxt = ST_SET_HR;
                ST_SET_HR: w_state_nxt = ST_SET_MIN;
                default:   w_state_nxt = ST_RUN;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Output and counter next values derived from the current transition
    always_comb begin
        w_inc_hr_nxt    = w_strobe & (r_state == ST_SET_HR);
        w_inc_min_nxt   = w_strobe & (r_state == ST_SET_MIN);
        w_to_nxt        = '0;
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = 1'b0;
        if (w_state_nxt == ST_RUN) begin
            w_blink_nxt = 1'b0;
        end else if (w_state_nxt != r_state || w_strobe) begin
            w_blink_nxt = 1'b1;
        end else begin
            w_to_nxt = r_to_cnt + CW'(1);
            if (r_blink_cnt == CW'(BLINK_CYCLES - 1)) begin
                w_blink_nxt = ~r_blink;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + CW'(1);
                w_blink_nxt     = r_blink;
            end
        end
    end

    // Registered outputs and timeout/blink counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_inc_hr    <= 1'b0;
            r_inc_min   <= 1'b0;
            r_run_en    <= 1'b1;
        end else begin
            r_to_cnt    <= w_to_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink     <= w_blink_nxt;
            r_inc_hr    <= w_inc_hr_nxt;
            r_inc_min   <= w_inc_min_nxt;
            r_run_en    <= (w_state_nxt == ST_RUN);
        end
    end

    assign mode    = r_state;
    assign run_en  = r_run_en;
    assign inc_hr  = r_inc_hr;
    assign inc_min = r_inc_min;
    assign blink   = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed plus randomized stimulus for clock_set_ctrl,
// checked cycle by cycle against a timestamp-based reference model.
module tb_clock_set_ctrl;

    localparam int LONG    = 8;
    localparam int REPEAT  = 4;
    localparam int TIMEOUT = 50;
    localparam int BLINK   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic [1:0] mode;
    logic       run_en;
    logic       inc_hr;
    logic       inc_min;
    logic       blink;

    clock_set_ctrl #(
        .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REPEAT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .BLINK_CYCLES(BLINK),
        .CW(32)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .mode(mode),
        .run_en(run_en),
        .inc_hr(inc_hr),
        .inc_min(inc_min),
        .blink(blink)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cnt_min = 0;
    int cnt_hr = 0;

    // Reference model state: times (cycle numbers) of the last relevant events
    int   m_n = 0;
    int   m_mode = 0;
    logic m_pm = 1'b0;
    logic m_pi = 1'b0;
    int   m_act = 0;
    int   m_bref = 0;
    int   m_hstart = 0;
    logic e_hr = 1'b0;
    logic e_min = 1'b0;
    logic e_blink = 1'b0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %02h expected %02h", tag, m_n, got, exp);
        end
    endtask

    task automatic model_step(input logic bm, input logic bi, input logic r);
        logic rm, ri, strobe;
        int   d;
        e_hr  = 1'b0;
        e_min = 1'b0;
        if (r) begin
            m_mode = 0;
            m_pm   = 1'b0;
            m_pi   = 1'b0;
        end else begin
            rm = bm & ~m_pm;
            ri = bi & ~m_pi;
            if (rm) begin
                m_mode   = (m_mode + 1) % 3;
                m_act    = m_n;
                m_bref   = m_n;
                m_hstart = m_n;
            end else if (m_mode != 0) begin
                strobe = ri;
                if (ri) begin
                    m_hstart = m_n;
                end else if (bi && m_pi) begin
                    d = m_n - m_hstart;
`ifdef CLOCK_SET_AUTOREPEAT_EN
                    if (d == LONG || (d > LONG && (d - LONG) % REPEAT == 0)) strobe = 1'b1;
`else
                    d = d + 0;
`endif
                end
                if (strobe) begin
                    e_hr   = (m_mode == 1);
                    e_min  = (m_mode == 2);
                    m_act  = m_n;
                    m_bref = m_n;
                end else if (m_n - m_act == TIMEOUT) begin
                    m_mode   = 0;
                    m_hstart = m_n;
                end
            end
            m_pm = bm;
            m_pi = bi;
        end
        e_blink = (m_mode != 0) && (((m_n - m_bref) / BLINK) % 2 == 0);
    endtask

    task automatic tick(input logic bm, input logic bi, input logic r);
        logic [7:0] got, exp;
        btn_mode = bm;
        btn_inc  = bi;
        rst      = r;
        @(posedge clk);
        model_step(bm, bi, r);
        #1;
        got = {2'b00, mode, run_en, inc_hr, inc_min, blink};
        exp = {2'b00, 2'(m_mode), (m_mode == 0), e_hr, e_min, e_blink};
        check("outs", got, exp);
        if (inc_min) cnt_min++;
        if (inc_hr) cnt_hr++;
        m_n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tap_mode();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic tap_inc();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset and release
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        idle(3);

        // Mode sequencing RUN -> SET_HR -> SET_MIN -> RUN
        tap_mode(); tap_mode(); tap_mode();
        idle(2);

        // Three taps in SET_HR, one ignored tap in RUN
        tap_mode();
        cnt_hr = 0;
        tap_inc(); tap_inc(); tap_inc();
        check("hr_taps", 8'(cnt_hr), 8'd3);
        tap_mode(); tap_mode();
        cnt_hr = 0; cnt_min = 0;
        tap_inc();
        idle(2);
        check("run_ignored", 8'(cnt_hr + cnt_min), 8'd0);

        // Hold inc for relative cycles 0..20 in SET_MIN
        tap_mode(); tap_mode();
        cnt_min = 0;
        for (int i = 0; i <= 20; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
`ifdef CLOCK_SET_AUTOREPEAT_EN
        check("hold_pulses", 8'(cnt_min), 8'd5);
`else
        check("hold_pulses", 8'(cnt_min), 8'd1);
`endif
        tap_mode();
        idle(2);

        // Idle in SET_HR: blink pattern, timeout, tap at idle cycle 40
        tap_mode();
        idle(39);
        tap_inc();
        idle(55);
        check("timeout_run", 8'(mode), 8'd0);

        // Simultaneous mode and inc rise in SET_HR
        tap_mode();
        cnt_hr = 0;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("simul_mode", 8'(mode), 8'd2);
        check("simul_nostrobe", 8'(cnt_hr), 8'd0);

        // Reset during hold in SET_MIN with inc still held
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        cnt_min = 0;
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1, 1'b0);
        check("rst_hold_nostrobe", 8'(cnt_min), 8'd0);
        tick(1'b0, 1'b0, 1'b0);

        // Randomized segments
        for (int it = 0; it < 400; it++) begin
            int act;
            act = int'($urandom_range(0, 11));
            case (act)
                0, 1: begin
                    for (int i = 0; i < int'($urandom_range(1, 2)); i++) tick(1'b1, 1'b0, 1'b0);
                    tick(1'b0, 1'b0, 1'b0);
                end
                2, 3, 4: begin
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'b0, 1'b1, 1'b0);
                    for (int i = 0; i < int'($urandom_range(1, 2)); i++) tick(1'b0, 1'b0, 1'b0);
                end
                5, 6: begin
                    for (int i = 0; i < int'($urandom_range(5, 30)); i++) tick(1'b0, 1'b1, 1'b0);
                    tick(1'b0, 1'b0, 1'b0);
                end
                7: idle(int'($urandom_range(1, 60)));
                8: begin
                    tick(1'b1, 1'b1, 1'b0);
                    tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                end
                9, 10: begin
                    for (int i = 0; i < 10; i++)
                        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0)
                        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
                    else
                        tick(1'b0, 1'b1, 1'b0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
